ram_stream_reader: RTL and testbench
====================================

# ram_stream_reader

Read-side initiator for the core-local `RAM` block: on a start command it walks a contiguous address range, issues one read per word, absorbs the RAM's one-cycle registered-address read latency, and presents the words on a valid/ready stream. It sits between a processor or DMA controller and a `RAM` instance. It drives that instance's `addr`/`wrEn`/`dataIn` and consumes its `dataOut`, for example to dump data memory to a UART or to the host-side result collector.

## Interface
- `WIDTH`, 12, data word width; must match the attached RAM.
- `DEPTH`, 256, number of RAM words; must match the attached RAM.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, RAM address width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first word address, latched with `start`.
- `length`  in  ADDR_WIDTH+1  word count, latched with `start`. 0 means no-op. Values above DEPTH are clamped to DEPTH.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_wrEn`  out  1  to RAM `wrEn`.
- `ram_dataIn`  out  WIDTH  to RAM `dataIn`; always 0.
- `ram_dataOut`  in  WIDTH  from RAM `dataOut`; valid the cycle after the address is driven.
- `out_data`  out  WIDTH  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready from the consumer.

## Operation
- States:
  - IDLE → READ on `start` when latched length ≠ 0.
  - IDLE → DONE on `start` when length = 0.
  - READ → DRAIN after the final read is issued.
  - DRAIN → DONE when the final word has been accepted (`out_valid & out_ready`).
  - DONE → IDLE unconditionally.
- Address counter starts at `base_addr` and increments modulo DEPTH: wrap from DEPTH-1 to 0 with no error.
- Output buffer: a 2-entry FIFO; the head drives `out_data`.
- A read is issued in a cycle only when (buffered words + reads in flight) < 2, after accounting for a same-cycle pop. The buffer therefore never overflows, and no data is dropped or duplicated.
- Data from a read issued in cycle c is sampled from `ram_dataOut` at the end of c+1 and pushed into the buffer.
- `out_valid` is registered and never depends combinationally on `out_ready`.
- `out_data` holds stable while `out_valid & !out_ready`.
- `start` is ignored while `busy` or in DONE.
- `ram_wrEn` is 0 at all times (without the macro).
- `ram_addr` holds its last value when idle.
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `ram_addr`=0, `ram_wrEn`=0. Buffer and counters are cleared.
- Reset mid-transfer aborts immediately: buffered words are discarded, no `done` is produced, and no RAM write is issued.

## Timing
- `start` sampled at edge E0; first `ram_addr` driven in cycle 1; data captured at E2; first `out_valid` in cycle 3. Start-to-first-word latency is 3 cycles.
- With `out_ready` held high, one word per cycle is sustained.
- `busy` is high from cycle 1 through the cycle of the last handshake.
- `done` is high in the cycle after the last handshake, with `busy` low.
- For length = 0: `done` pulses in cycle 1, `busy` is never asserted, and there is no RAM access.

## Configuration
- `RAM_READER_CLEAR_EN`: clear-after-read.
  - When defined: each read of address a in cycle c is followed in c+1 by a write to the same address (`ram_addr`=a, `ram_wrEn`=1, `ram_dataIn`=0). The captured word is unaffected. The next read is issued no earlier than c+2, so peak throughput is 1 word per 2 cycles. Reset during a clear cycle suppresses that write.
  - When undefined: `ram_wrEn` is tied to 0 and throughput is 1 word per cycle.

## Test plan
- RAM[0..3]=0x101,0x102,0x103,0x104; `start` with base=0, len=4, ready=1 → `out_valid` first in cycle 3; words 0x101..0x104 on consecutive cycles; `done` one cycle after the last word; `busy` low with `done`.
- Same preload, `out_ready` pattern 1,0,0,1,0,1,1 → exactly 4 words in order, `out_data` stable during stalls, never more than 2 words buffered or in flight.
- base=254, len=4 (DEPTH=256) → RAM reads 254, 255, 0, 1 in that order; the stream matches their contents.
- len=0 → `done` in cycle 1, no `out_valid`, `ram_addr` unchanged. len=300 → exactly 256 words.
- `rst` pulse after 2 of 8 words accepted → the next cycle has `out_valid`=0, `busy`=0, `done`=0, `ram_wrEn`=0. A following `start` with base=0, len=2 returns RAM[0], RAM[1] with 3-cycle latency.
- With `RAM_READER_CLEAR_EN`: RAM[8..10]=0x0AA,0x0BB,0x0CC; base=8, len=3, ready=1 → stream is 0x0AA, 0x0BB, 0x0CC at 2-cycle spacing, and RAM[8..10] read back 0 after `done`.

Source files
------------

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a RAM address range and presents the words on a valid/ready stream.
// Optional RAM_READER_CLEAR_EN: each word is zeroed in the RAM in the cycle after it is read.
module ram_stream_reader #(
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wrEn,
  output logic [WIDTH-1:0]      ram_dataIn,
  input  logic [WIDTH-1:0]      ram_dataOut,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            o_dbg_state
);

  // Stream handshake: a word moves on every cycle where out_valid & out_ready.
  // out_valid comes straight from a register, and a shown word holds until taken.

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   L_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] L_LAST  = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_left;
  logic                  r_pend;
  logic [WIDTH-1:0]      r_buf [2];
  logic                  r_head;
  logic [1:0]            r_count;
  logic                  r_valid;
`ifdef RAM_READER_CLEAR_EN
  logic                  r_clr;
`endif

  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_wr_idx;
  logic [ADDR_WIDTH:0]   w_len;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  assign w_pop      = r_valid & out_ready;
  // Buffer occupancy after this edge; a read is only issued if its word is sure to fit.
  assign w_occ      = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_pend};
`ifdef RAM_READER_CLEAR_EN
  assign w_issue    = (r_state == S_READ) && !r_clr && (w_occ < 3'd2);
`else
  assign w_issue    = (r_state == S_READ) && (w_occ < 3'd2);
`endif
  assign w_wr_idx   = r_head ^ r_count[0];
  assign w_len      = (length > L_DEPTH) ? L_DEPTH : length;
  assign w_addr_inc = (r_addr == L_LAST) ? '0 : r_addr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_addr   <= '0;
      r_left   <= '0;
      r_pend   <= 1'b0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_head   <= 1'b0;
      r_count  <= 2'd0;
      r_valid  <= 1'b0;
`ifdef RAM_READER_CLEAR_EN
      r_clr    <= 1'b0;
`endif
    end else begin
      if (r_pend) r_buf[w_wr_idx] <= ram_dataOut;
      if (w_pop) r_head <= ~r_head;
      r_count <= w_occ[1:0];
      r_valid <= (w_occ != 3'd0);
      r_pend  <= w_issue;
`ifdef RAM_READER_CLEAR_EN
      // The address stays put for the clear cycle and advances afterwards.
      r_clr <= w_issue;
      if (r_clr) r_addr <= w_addr_inc;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_busy  <= 1'b1;
              r_addr  <= base_addr;
              r_left  <= w_len;
            end
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_left <= r_left - L_ONE;
`ifndef RAM_READER_CLEAR_EN
            r_addr <= w_addr_inc;
`endif
            if (r_left == L_ONE) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && (r_count == 2'd1) && !r_pend) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign ram_addr    = r_addr;
  assign ram_dataIn  = '0;
`ifdef RAM_READER_CLEAR_EN
  assign ram_wrEn    = r_clr & ~rst;
`else
  assign ram_wrEn    = 1'b0;
`endif
  assign out_data    = r_buf[r_head];
  assign out_valid   = r_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: drives ram_stream_reader against a behavioural RAM and checks
// every streamed word, handshake timing and status outputs against an address-walk model.
module tb_ram_stream_reader;

  localparam int W  = 12;
  localparam int D  = 256;
  localparam int AW = 8;
`ifdef RAM_READER_CLEAR_EN
  localparam int SPACE = 2;
`else
  localparam int SPACE = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, ram_wrEn, out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_dataIn, ram_dataOut, out_data;
  logic [1:0]    dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  ram_stream_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_wrEn(ram_wrEn),
    .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .o_dbg_state(dbg_state)
  );

  // RAM with registered read address; bench write port used only for preloading
  logic [W-1:0]  mem [D];
  logic [AW-1:0] ram_q = '0;
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [W-1:0]  tb_wd = '0;
  always @(posedge clk) begin
    if (ram_wrEn) mem[ram_addr] <= ram_dataIn;
    else if (tb_we) mem[tb_wa] <= tb_wd;
    ram_q <= ram_addr;
  end
  assign ram_dataOut = mem[ram_q];

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input int v);
    tb_we = 1'b1; tb_wa = AW'(a); tb_wd = W'(v);
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc < 3) ? 1'b1 : (pat[(cyc - 3) % 7] != 0);
    return ($urandom_range(0, 1) == 1);
  endfunction

  // driver: one transfer; cycle 0 holds start, checks run at each negedge
  task automatic xfer(input int base, input int len, input int mode);
    int n, cyc, got, first_v, first_hs, last_hs;
    logic seen_done, prev_stall;
    logic [W-1:0] prev_d;
    logic [AW-1:0] addr0;
    n = (len > D) ? D : len;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % D]);
    addr0 = ram_addr;
    start = 1'b1; base_addr = AW'(base); length = (AW+1)'(len); out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; got = 0; first_v = -1; first_hs = -1; last_hs = 0;
    seen_done = 1'b0; prev_stall = 1'b0; prev_d = '0;
    while (!seen_done && cyc < 4 * D + 40) begin
      out_ready = ready_for(mode, cyc);
      if (mode == 2) begin
        // commands during a transfer must be ignored
        start = ($urandom_range(0, 3) == 0);
        base_addr = AW'($urandom_range(0, D - 1));
        length = (AW+1)'($urandom_range(1, 9));
      end
      @(negedge clk);
      if (cyc == 1 && n > 0) check_eq("first_addr", ram_addr, base % D);
      if (n == 0) check_eq("noop_addr", ram_addr, addr0);
      check_eq("busy", busy, (n > 0 && got < n));
`ifndef RAM_READER_CLEAR_EN
      check_eq("wren", ram_wrEn, 0);
`endif
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, prev_d);
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("extra_word", got + 1, n);
        else check_eq("data", out_data, exp_q.pop_front());
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        got++;
      end
      if (done) begin
        seen_done = 1'b1;
        check_eq("done_cycle", cyc, last_hs + 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check_eq("finished", seen_done, 1);
    check_eq("word_count", got, n);
    if (n > 0) check_eq("latency", first_v, 3);
    else check_eq("no_valid", first_v, -1);
    if (n > 0 && mode == 0) check_eq("spacing", last_hs - first_hs, SPACE * (n - 1));
    @(negedge clk);
    check_eq("done_pulse", done, 0);
    check_eq("idle_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic abort_test();
    int acc = 0;
    int cyc = 0;
    start = 1'b1; base_addr = '0; length = 9'd8; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (acc < 2 && cyc < 20) begin
      @(negedge clk);
      if (out_valid && out_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("abort_reach", acc, 2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_nowrite", ram_wrEn, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_wren", ram_wrEn, 0);
    @(posedge clk); #1;
    xfer(0, 2, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_addr", ram_addr, 0);
    check_eq("rst_wren", ram_wrEn, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int a = 0; a < D; a++) poke(a, $urandom_range(0, (1 << W) - 1));
    for (int a = 0; a < 4; a++) poke(a, 'h101 + a);
    poke(8, 'h0AA); poke(9, 'h0BB); poke(10, 'h0CC);

    xfer(0, 4, 0);
    xfer(0, 4, 1);
    xfer(254, 4, 0);
    xfer(0, 0, 0);
    xfer(8, 3, 0);
`ifdef RAM_READER_CLEAR_EN
    for (int a = 8; a < 11; a++) check_eq("cleared", mem[a], 0);
`endif
    xfer(17, 300, 0);
    abort_test();

    for (int t = 0; t < 8; t++) begin
      repeat (3) poke($urandom_range(0, D - 1), $urandom_range(0, (1 << W) - 1));
      xfer($urandom_range(0, D - 1), $urandom_range(0, 40), 2);
    end
    xfer($urandom_range(0, D - 1), $urandom_range(257, 320), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
